// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fetch/data arbiter onto one memory port; ports: if_* fetch side, d_* data side, mem_* memory side, busy/err status
module mem_port_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          if_gnt,
  output logic          d_gnt,
  output logic          if_rvalid,
  output logic          d_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          busy,
  output logic          err
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic own_f, rdy, flushed;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic pick_f, kill, tmo;
  assign pick_f = if_req && (!d_req || starve_cnt == SW'(STARVE_MAX));
  assign kill = own_f && (flushed || if_flush);
  assign tmo = tmo_cnt == TW'(TIMEOUT - 1);
  // rdy gives one dead IDLE cycle after reset release and after every transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      own_f <= 1'b0;
      rdy <= 1'b0;
      flushed <= 1'b0;
      starve_cnt <= '0;
      tmo_cnt <= '0;
      if_gnt <= 1'b0;
      d_gnt <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if_rdata <= '0;
      d_rdata <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      busy <= 1'b0;
      err <= 1'b0;
    end else begin
      if_gnt <= 1'b0;
      d_gnt <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (state == IDLE) begin
        if (!rdy) rdy <= 1'b1;
        else if (if_req || d_req) begin
          state <= BUSY;
          busy <= 1'b1;
          mem_en <= 1'b1;
          own_f <= pick_f;
          mem_we <= !pick_f && d_we;
          mem_addr <= pick_f ? if_addr : d_addr;
          mem_wdata <= pick_f ? '0 : d_wdata;
          if_gnt <= pick_f;
          d_gnt <= !pick_f;
          tmo_cnt <= '0;
          flushed <= 1'b0;
          starve_cnt <= pick_f ? '0 : (if_req && starve_cnt != SW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
        end
      end else if (mem_ready || tmo) begin
        state <= IDLE;
        busy <= 1'b0;
        mem_en <= 1'b0;
        rdy <= 1'b0;
        if (!mem_ready) err <= 1'b1;
        if (own_f) begin
          if (!kill) begin
            if_rvalid <= 1'b1;
            if_rdata <= mem_ready ? mem_rdata : '0;
          end
        end else begin
          d_rvalid <= 1'b1;
          if (!mem_we || !mem_ready) d_rdata <= mem_ready ? mem_rdata : '0;
        end
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (own_f && if_flush) flushed <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic if_req = 1'b0, if_flush = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [9:0] if_addr = '0, d_addr = '0;
  logic [31:0] d_wdata = '0, mem_rdata = '0;
  logic if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy, err;
  logic [31:0] if_rdata, d_rdata, mem_wdata;
  logic [9:0] mem_addr;
  int cmp = 0, errs = 0;
  logic [31:0] exp_if = '0, exp_d = '0;
  logic exp_err = 1'b0;

  mem_port_arbiter #(.AW(10), .DW(32), .STARVE_MAX(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .if_gnt(if_gnt), .d_gnt(d_gnt),
    .if_rvalid(if_rvalid), .d_rvalid(d_rvalid), .if_rdata(if_rdata), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic apply_reset;
    tick;
    {if_req, d_req, if_flush, mem_ready} = '0;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    exp_if = '0;
    exp_d = '0;
    exp_err = 1'b0;
  endtask

  task automatic do_txn(input bit is_f, input bit we, input logic [9:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int lat, input int flush_at, input bit idle_flush,
                        input bit intrude);
    bit got = 0, kill = 0, ewe;
    ewe = we && !is_f;
    if (is_f) begin if_req = 1'b1; if_addr = addr; end
    else begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; end
    if_flush = idle_flush;
    for (int i = 0; i < 10 && !got; i++) begin
      tick;
      if (if_gnt || d_gnt) got = 1;
    end
    if_flush = 1'b0;
    if_req = 1'b0;
    d_req = 1'b0;
    cmp++;
    if ({if_gnt, d_gnt} !== {is_f, !is_f}) begin
      errs++;
      $display("FAIL gnt: got if/d=%b%b required %b%b", if_gnt, d_gnt, is_f, !is_f);
    end
    if (!got) return;
    cmp++;
    if ({mem_en, busy, mem_we, mem_addr} !== {1'b1, 1'b1, ewe, addr} || (ewe && mem_wdata !== wd)) begin
      errs++;
      $display("FAIL bus_load: got en/busy/we=%b%b%b addr=%h wdata=%h required %b%b%b addr=%h wdata=%h",
               mem_en, busy, mem_we, mem_addr, mem_wdata, 1'b1, 1'b1, ewe, addr, wd);
    end
    for (int c = 1; c <= 15; c++) begin
      mem_ready = (c == lat);
      mem_rdata = (c == lat) ? rd : $urandom;
      if_flush = (c == flush_at);
      if (is_f && c == flush_at) kill = 1;
      if (intrude) begin if (is_f) d_req = 1'b1; else if_req = 1'b1; end
      tick;
      mem_ready = 1'b0;
      if_flush = 1'b0;
      if (c != lat && c != 15) begin
        cmp++;
        if ({if_rvalid, d_rvalid, if_gnt, d_gnt, mem_en, busy, mem_we, mem_addr} !== {4'b0, 1'b1, 1'b1, ewe, addr}) begin
          errs++;
          $display("FAIL busy_hold c=%0d: got rv=%b%b gnt=%b%b en=%b busy=%b we=%b addr=%h required rv=00 gnt=00 en=1 busy=1 we=%b addr=%h",
                   c, if_rvalid, d_rvalid, if_gnt, d_gnt, mem_en, busy, mem_we, mem_addr, ewe, addr);
        end
      end else begin
        if_req = 1'b0;
        d_req = 1'b0;
        if (c != lat) exp_err = 1'b1;
        if (is_f) begin
          if (!kill) exp_if = (c == lat) ? rd : '0;
        end else if (!we || c != lat) exp_d = (c == lat) ? rd : '0;
        cmp++;
        if ({if_rvalid, d_rvalid, mem_en, busy} !== {is_f && !kill, !is_f, 2'b00}) begin
          errs++;
          $display("FAIL complete: got rv=%b%b en=%b busy=%b required rv=%b%b en=0 busy=0",
                   if_rvalid, d_rvalid, mem_en, busy, is_f && !kill, !is_f);
        end
        cmp++;
        if (if_rdata !== exp_if) begin errs++; $display("FAIL if_rdata: got %h required %h", if_rdata, exp_if); end
        cmp++;
        if (d_rdata !== exp_d) begin errs++; $display("FAIL d_rdata: got %h required %h", d_rdata, exp_d); end
        cmp++;
        if (err !== exp_err) begin errs++; $display("FAIL err: got %b required %b", err, exp_err); end
        break;
      end
    end
    tick;
    cmp++;
    if ({if_rvalid, d_rvalid, if_gnt, d_gnt, mem_en} !== 5'b0) begin
      errs++;
      $display("FAIL post_idle: got rv=%b%b gnt=%b%b en=%b required all 0", if_rvalid, d_rvalid, if_gnt, d_gnt, mem_en);
    end
  endtask

  task automatic test_reset;
    tick;
    rst_n = 1'b0;
    #1;
    cmp++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, if_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, err} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: got nonzero outputs en=%b busy=%b err=%b addr=%h required all 0", mem_en, busy, err, mem_addr);
    end
    tick;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h0AB;
    rst_n = 1'b1;
    tick;
    cmp++;
    if (d_gnt !== 1'b0) begin errs++; $display("FAIL early_grant: got d_gnt=%b required 0", d_gnt); end
    tick;
    cmp++;
    if ({d_gnt, mem_addr} !== {1'b1, 10'h0AB}) begin
      errs++;
      $display("FAIL first_grant: got d_gnt=%b addr=%h required 1 addr=0ab", d_gnt, mem_addr);
    end
    d_req = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'h0BADF00D;
    tick;
    mem_ready = 1'b0;
    exp_d = 32'h0BADF00D;
    cmp++;
    if ({d_rvalid, d_rdata} !== {1'b1, exp_d}) begin
      errs++;
      $display("FAIL first_read: got rv=%b rdata=%h required 1 %h", d_rvalid, d_rdata, exp_d);
    end
    tick;
  endtask

  task automatic test_read;
    do_txn(0, 0, 10'h005, 32'h0, 32'h12345678, 2, 0, 0, 0);
  endtask

  task automatic test_write;
    do_txn(0, 1, 10'h3FF, 32'hCAFEF00D, 32'hDEADBEEF, 3, 0, 0, 0);
  endtask

  task automatic test_timeout;
    do_txn(1, 0, 10'h020, 32'h0, 32'h55AA55AA, 15, 0, 0, 0);
    do_txn(1, 0, 10'h021, 32'h0, 32'h77777777, 0, 0, 0, 0);
    do_txn(0, 0, 10'h022, 32'h0, 32'h13579BDF, 1, 0, 0, 0);
  endtask

  task automatic test_flush;
    do_txn(1, 0, 10'h010, 32'h0, 32'hF00DF00D, 4, 2, 0, 0);
    do_txn(1, 0, 10'h011, 32'h0, 32'hABCD0123, 3, 3, 0, 0);
    do_txn(1, 0, 10'h012, 32'h0, 32'h11112222, 2, 0, 1, 0);
    do_txn(0, 0, 10'h013, 32'h0, 32'h33334444, 3, 2, 0, 0);
  endtask

  task automatic test_starve;
    int k = 0, last = 0;
    apply_reset;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; mem_ready = 1'b1;
    for (int t = 0; t < 100 && k < 10; t++) begin
      tick;
      if (if_gnt || d_gnt) begin
        cmp++;
        if ({if_gnt, d_gnt} !== {k % 5 == 4, k % 5 != 4}) begin
          errs++;
          $display("FAIL starve_order k=%0d: got if/d=%b%b required %b%b", k, if_gnt, d_gnt, k % 5 == 4, k % 5 != 4);
        end
        if (k > 0) begin
          cmp++;
          if (t - last !== 3) begin errs++; $display("FAIL grant_gap k=%0d: got %0d required 3", k, t - last); end
        end
        last = t;
        k++;
      end
    end
    cmp++;
    if (k !== 10) begin errs++; $display("FAIL starve_count: got %0d grants required 10", k); end
    apply_reset;
    tick;
  endtask

  task automatic test_reset_busy;
    bit got = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h155;
    for (int i = 0; i < 10 && !got; i++) begin
      tick;
      if (d_gnt) got = 1;
    end
    d_req = 1'b0;
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    cmp++;
    if ({if_gnt, d_gnt, if_rvalid, d_rvalid, if_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, err} !== '0 || !got) begin
      errs++;
      $display("FAIL reset_busy: got en=%b busy=%b addr=%h granted=%b required en=0 busy=0 addr=000 granted=1", mem_en, busy, mem_addr, got);
    end
    tick;
    rst_n = 1'b1;
    exp_if = '0; exp_d = '0; exp_err = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      cmp++;
      if ({if_rvalid, d_rvalid, mem_en} !== 3'b0) begin
        errs++;
        $display("FAIL reset_no_rvalid i=%0d: got rv=%b%b en=%b required 000", i, if_rvalid, d_rvalid, mem_en);
      end
    end
    mem_ready = 1'b0;
    tick;
  endtask

  task automatic test_random;
    bit is_f;
    for (int n = 0; n < 40; n++) begin
      is_f = 1'($urandom % 2);
      do_txn(is_f, 1'($urandom % 2), 10'($urandom), $urandom, $urandom, int'($urandom_range(1, 8)),
             (is_f && $urandom % 3 == 0) ? int'($urandom_range(1, 10)) : 0,
             1'($urandom % 4 == 0), 1'($urandom % 2));
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_flush;
    test_timeout;
    test_reset_busy;
    test_random;
    test_starve;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, 10, address width; covers 1024-word Mem.
REQ-002 Parameter DW, 32, data width.
REQ-003 Parameter STARVE_MAX, 4, consecutive data wins after which a waiting fetch is forced through.
REQ-004 Parameter TIMEOUT, 15, maximum BUSY cycles waiting for mem_ready before abort.
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 clk  in  1  sole clock; all state changes on posedge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 if_req  in  1  fetch request; held until if_gnt.
REQ-009 if_addr  in  AW  fetch word address.
REQ-010 if_flush  in  1  taken-branch kill of any outstanding fetch response.
REQ-011 d_req  in  1  data request; held until d_gnt.
REQ-012 d_we  in  1  data write (1) / read (0).
REQ-013 d_addr  in  AW  data word address.
REQ-014 d_wdata  in  DW  store data.
REQ-015 mem_rdata  in  DW  memory read data, valid with mem_ready.
REQ-016 mem_ready  in  1  memory completion strobe.
REQ-017 if_gnt, d_gnt  out  1 each  one-cycle grant pulses.
REQ-018 if_rvalid, d_rvalid  out  1 each  one-cycle completion pulses.
REQ-019 if_rdata, d_rdata  out  DW each  registered read data.
REQ-020 mem_en, mem_we  out  1 each  memory strobe and write enable.
REQ-021 mem_addr, mem_wdata  out  AW, DW  registered memory address and write data.
REQ-022 busy  out  1  high while the FSM is not in IDLE.
REQ-023 err  out  1  sticky timeout flag.

Function
REQ-024 The FSM SHALL have states IDLE and BUSY; all outputs SHALL be registered.
REQ-025 In IDLE with any request, the next edge SHALL select a winner, load mem_addr/mem_we/mem_wdata from that requester, raise mem_en, pulse the winner's gnt for exactly that one cycle, and enter BUSY.
REQ-026 Arbitration SHALL grant data over fetch, except that fetch SHALL win when starve_cnt == STARVE_MAX.
REQ-027 starve_cnt SHALL increment, saturating at STARVE_MAX, on every data grant while if_req is high; it SHALL clear to 0 on every fetch grant.
REQ-028 mem_en and the memory bus outputs SHALL hold constant throughout BUSY.
REQ-029 On the BUSY edge with mem_ready=1, the FSM SHALL drop mem_en, pulse the owner's rvalid for one cycle, and return to IDLE.
REQ-030 On that same edge, reads SHALL load mem_rdata into the owner's rdata; writes SHALL pulse d_rvalid as an acknowledge and leave d_rdata unchanged.
REQ-031 There SHALL be at least one IDLE cycle between transactions, giving a minimum of 3 cycles from grant edge to next grant edge.
REQ-032 A BUSY cycle counter SHALL abort the transaction when it reaches TIMEOUT without mem_ready: set err, pulse the owner's rvalid with rdata = 0, and return to IDLE.
REQ-033 err SHALL be sticky and cleared only by reset.
REQ-034 if_flush high during a fetch-owned BUSY cycle or on its completion edge SHALL suppress if_rvalid and leave if_rdata unchanged; the memory transaction still runs to mem_ready.
REQ-035 if_flush SHALL have no effect on data transactions or in IDLE.
REQ-036 Requests arriving during BUSY SHALL be ignored until IDLE; the other requester's gnt SHALL stay low.
REQ-037 Simultaneous mem_ready and timeout on the same edge SHALL be treated as normal completion, with err unchanged.

Reset
REQ-038 rst_n low SHALL immediately force state IDLE, starve_cnt and the timeout counter to 0, and every output including rdata, mem_addr, mem_wdata and err to 0.
REQ-039 Reset during BUSY SHALL abandon the transaction with no rvalid pulse after release.
REQ-040 The first grant SHALL occur no earlier than the second posedge after rst_n deasserts.

Verification
REQ-041 Read path: d_req read at addr 0x005, memory returns 0x1234_5678 two cycles later -> d_gnt one pulse, d_rvalid one pulse, d_rdata = 0x12345678, busy low afterwards.
REQ-042 Arbitration and starvation: if_req and d_req held continuously with STARVE_MAX = 4 -> grant order D,D,D,D,F,D,D,D,D,F.
REQ-043 Timeout: mem_ready held low for 15 BUSY cycles on a fetch -> if_rvalid pulse, if_rdata = 0, err = 1, and err still 1 after the next successful transaction.
REQ-044 Flush: fetch to 0x010, if_flush pulsed mid-BUSY -> no if_rvalid, if_rdata unchanged, and the next fetch is granted normally.
REQ-045 Write: d_we = 1, d_addr = 0x3FF, d_wdata = 0xCAFEF00D -> mem_we = 1, mem_addr = 0x3FF, mem_wdata = 0xCAFEF00D held until mem_ready, then d_rvalid pulse with d_rdata unchanged.
REQ-046 Reset in BUSY: rst_n pulsed low mid-read -> mem_en low immediately, all outputs 0, and no rvalid pulse after release.
